// File: rtl/serial_to_symbol_packer.sv
// Serial-to-parallel packer: gathers a 1-bit stream into 1/2/4/6-bit
// right-aligned symbols for the QAM mapper, with a valid/ready output stage.
module serial_to_symbol_packer #(
  parameter int unsigned MAX_BITS  = 6,
  parameter int unsigned MSB_FIRST = 0,
  parameter int unsigned CNT_W     = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mod_type,
  input  logic                sync_clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_bit,
  output logic                sym_valid,
  input  logic                sym_ready,
  output logic [MAX_BITS-1:0] sym_data,
  output logic [CNT_W-1:0]    sym_bits,
  output logic [1:0]          sym_mode,
  output logic                busy
);

  // Bits per symbol for each modulation
  function automatic logic [CNT_W-1:0] mode_bits(input logic [1:0] m);
    case (m)
      2'd0:    mode_bits = CNT_W'(1);
      2'd1:    mode_bits = CNT_W'(2);
      2'd2:    mode_bits = CNT_W'(4);
      default: mode_bits = CNT_W'(6);
    endcase
  endfunction

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MAX_BITS-1:0] asm_q, asm_d;
  logic [1:0]          mode_q, mode_d;
  logic                sym_valid_q, sym_valid_d;
  logic [MAX_BITS-1:0] sym_data_q, sym_data_d;
  logic [CNT_W-1:0]    sym_bits_q, sym_bits_d;
  logic [1:0]          sym_mode_q, sym_mode_d;
  logic                busy_q, busy_d;

  logic [1:0]          eff_mode_c;
  logic [CNT_W-1:0]    n_c;
  logic [CNT_W-1:0]    pos_c;
  logic                last_c;
  logic                accept_c;
  logic [MAX_BITS-1:0] asm_new_c;

  // Next-state: bit insertion, symbol completion, output handshake, flush
  always_comb begin
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    mode_d      = mode_q;
    sym_valid_d = sym_valid_q;
    sym_data_d  = sym_data_q;
    sym_bits_d  = sym_bits_q;
    sym_mode_d  = sym_mode_q;

    // Live mode governs the first bit; afterwards the mode latched on bit 0
    eff_mode_c = (cnt_q == '0) ? mod_type : mode_q;
    n_c        = mode_bits(eff_mode_c);
    last_c     = (cnt_q == n_c - CNT_W'(1));
    // Only the completing bit stalls, and only into a full, non-draining output
    in_ready   = !(last_c && sym_valid_q && !sym_ready);
    accept_c   = in_valid && in_ready && !sync_clr;
    pos_c      = (MSB_FIRST != 0) ? (n_c - CNT_W'(1) - cnt_q) : cnt_q;

    asm_new_c = asm_q;
    for (int i = 0; i < int'(MAX_BITS); i++) begin
      if (CNT_W'(i) == pos_c) asm_new_c[i] = in_bit;
    end

    if (sym_valid_q && sym_ready) sym_valid_d = 1'b0;

    if (sync_clr) begin
      cnt_d = '0;
      asm_d = '0;
    end else if (accept_c) begin
      if (cnt_q == '0) mode_d = mod_type;
      if (last_c) begin
        sym_valid_d = 1'b1;
        sym_data_d  = asm_new_c;
        sym_bits_d  = n_c;
        sym_mode_d  = eff_mode_c;
        cnt_d       = '0;
        asm_d       = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        asm_d = asm_new_c;
      end
    end

    busy_d = (cnt_d != '0);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      asm_q       <= '0;
      mode_q      <= '0;
      sym_valid_q <= 1'b0;
      sym_data_q  <= '0;
      sym_bits_q  <= '0;
      sym_mode_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      mode_q      <= mode_d;
      sym_valid_q <= sym_valid_d;
      sym_data_q  <= sym_data_d;
      sym_bits_q  <= sym_bits_d;
      sym_mode_q  <= sym_mode_d;
      busy_q      <= busy_d;
    end
  end

  assign sym_valid = sym_valid_q;
  assign sym_data  = sym_data_q;
  assign sym_bits  = sym_bits_q;
  assign sym_mode  = sym_mode_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_to_symbol_packer.sv
// Directed bench for serial_to_symbol_packer; LSB-first and MSB-first
// instances share all inputs.
module tb_serial_to_symbol_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mod_type;
  logic       sync_clr;
  logic       in_valid;
  logic       in_bit;
  logic       sym_ready;

  logic       in_ready,  in_ready_m;
  logic       sym_valid, sym_valid_m;
  logic [5:0] sym_data,  sym_data_m;
  logic [2:0] sym_bits,  sym_bits_m;
  logic [1:0] sym_mode,  sym_mode_m;
  logic       busy,      busy_m;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_to_symbol_packer #(.MAX_BITS(6), .MSB_FIRST(0), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .mod_type(mod_type), .sync_clr(sync_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data),
    .sym_bits(sym_bits), .sym_mode(sym_mode), .busy(busy)
  );

  serial_to_symbol_packer #(.MAX_BITS(6), .MSB_FIRST(1), .CNT_W(3)) dut_m (
    .clk(clk), .rst_n(rst_n), .mod_type(mod_type), .sync_clr(sync_clr),
    .in_valid(in_valid), .in_ready(in_ready_m), .in_bit(in_bit),
    .sym_valid(sym_valid_m), .sym_ready(sym_ready), .sym_data(sym_data_m),
    .sym_bits(sym_bits_m), .sym_mode(sym_mode_m), .busy(busy_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present one bit for one clock, return #1 after the edge
  task automatic send(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; mod_type = 2'd0; sync_clr = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; sym_ready = 1'b1;
    #12;
    check("rst_valid", 32'(sym_valid), 32'd0);
    check("rst_data",  32'(sym_data),  32'd0);
    check("rst_bits",  32'(sym_bits),  32'd0);
    check("rst_mode",  32'(sym_mode),  32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_ready", 32'(in_ready),  32'd1);
    rst_n = 1'b1;
    idle();

    // 1: QPSK, bits 1,0,1,1
    mod_type = 2'd1;
    send(1'b1);
    check("t1_busy",   32'(busy),      32'd1);
    check("t1_nv0",    32'(sym_valid), 32'd0);
    send(1'b0);
    check("t1_v1",     32'(sym_valid), 32'd1);
    check("t1_d1",     32'(sym_data),  32'h01);
    check("t1_b1",     32'(sym_bits),  32'd2);
    check("t1_m1",     32'(sym_mode),  32'd1);
    check("t1_d1m",    32'(sym_data_m), 32'h02);
    send(1'b1);
    check("t1_drain",  32'(sym_valid), 32'd0);
    send(1'b1);
    check("t1_v2",     32'(sym_valid), 32'd1);
    check("t1_d2",     32'(sym_data),  32'h03);
    idle();
    check("t1_idle",   32'(sym_valid), 32'd0);

    // 2: 64QAM 1,0,1,1,0,1 then BPSK 1,0 back-to-back
    mod_type = 2'd3;
    send(1'b1); send(1'b0); send(1'b1); send(1'b1); send(1'b0);
    check("t2_nv",     32'(sym_valid), 32'd0);
    send(1'b1);
    check("t2_d",      32'(sym_data_m), 32'h2D);
    check("t2_dl",     32'(sym_data),   32'h2D);
    check("t2_b",      32'(sym_bits_m), 32'd6);
    check("t2_m",      32'(sym_mode_m), 32'd3);
    mod_type = 2'd0;
    send(1'b1);
    check("t2_bv1",    32'(sym_valid), 32'd1);
    check("t2_bd1",    32'(sym_data),  32'h01);
    check("t2_bb1",    32'(sym_bits),  32'd1);
    check("t2_bm1",    32'(sym_mode),  32'd0);
    send(1'b0);
    check("t2_bv2",    32'(sym_valid), 32'd1);
    check("t2_bd2",    32'(sym_data),  32'h00);
    check("t2_busy",   32'(busy),      32'd0);
    idle();

    // 3: 16QAM, switch to QPSK after two bits
    mod_type = 2'd2;
    send(1'b1); send(1'b1);
    mod_type = 2'd1;
    send(1'b0);
    check("t3_nv",     32'(sym_valid), 32'd0);
    send(1'b1);
    check("t3_v",      32'(sym_valid), 32'd1);
    check("t3_d",      32'(sym_data),  32'h0B);
    check("t3_dm",     32'(sym_data_m), 32'h0D);
    check("t3_b",      32'(sym_bits),  32'd4);
    check("t3_m",      32'(sym_mode),  32'd2);
    send(1'b0); send(1'b1);
    check("t3_d2",     32'(sym_data),  32'h02);
    check("t3_d2m",    32'(sym_data_m), 32'h01);
    check("t3_b2",     32'(sym_bits),  32'd2);
    check("t3_m2",     32'(sym_mode),  32'd1);
    idle();

    // 4: 16QAM under backpressure, 8 bits 1,0,0,0,0,1,1,1
    mod_type = 2'd2; sym_ready = 1'b0;
    send(1'b1); send(1'b0); send(1'b0); send(1'b0);
    check("t4_v1",     32'(sym_valid), 32'd1);
    check("t4_d1",     32'(sym_data),  32'h01);
    send(1'b0); send(1'b1);
    check("t4_rdy7",   32'(in_ready),  32'd1);
    send(1'b1);
    check("t4_hold",   32'(sym_data),  32'h01);
    check("t4_busy",   32'(busy),      32'd1);
    in_valid = 1'b1; in_bit = 1'b1;
    #1;
    check("t4_stall",  32'(in_ready),   32'd0);
    check("t4_stallm", 32'(in_ready_m), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t4_hold2",  32'(sym_data),  32'h01);
    check("t4_v2",     32'(sym_valid), 32'd1);
    check("t4_busy2",  32'(busy),      32'd1);
    sym_ready = 1'b1;
    #1;
    check("t4_go",     32'(in_ready),  32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t4_v3",     32'(sym_valid), 32'd1);
    check("t4_d2",     32'(sym_data),  32'h0E);
    check("t4_d2m",    32'(sym_data_m), 32'h07);
    check("t4_busy3",  32'(busy),      32'd0);
    idle();
    check("t4_empty",  32'(sym_valid), 32'd0);

    // 5: sync_clr after 3 of 4 bits with a pending output symbol
    mod_type = 2'd1; sym_ready = 1'b0;
    send(1'b1); send(1'b1);
    check("t5_pend",   32'(sym_data),  32'h03);
    mod_type = 2'd2;
    send(1'b1); send(1'b0); send(1'b1);
    sync_clr = 1'b1;
    send(1'b1);
    sync_clr = 1'b0;
    check("t5_busy",   32'(busy),      32'd0);
    check("t5_busym",  32'(busy_m),    32'd0);
    check("t5_keepv",  32'(sym_valid), 32'd1);
    check("t5_keepd",  32'(sym_data),  32'h03);
    check("t5_keepm",  32'(sym_mode),  32'd1);
    sym_ready = 1'b1;
    send(1'b0);
    check("t5_drain",  32'(sym_valid), 32'd0);
    send(1'b1); send(1'b0); send(1'b1);
    check("t5_v",      32'(sym_valid), 32'd1);
    check("t5_d",      32'(sym_data),  32'h0A);
    check("t5_dm",     32'(sym_data_m), 32'h05);
    check("t5_m",      32'(sym_mode),  32'd2);
    idle();

    // 6: async reset mid-symbol with a pending symbol
    mod_type = 2'd1; sym_ready = 1'b0;
    send(1'b1); send(1'b0);
    mod_type = 2'd2;
    send(1'b1); send(1'b1);
    check("t6_pre",    32'(sym_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_valid",  32'(sym_valid),   32'd0);
    check("t6_validm", 32'(sym_valid_m), 32'd0);
    check("t6_data",   32'(sym_data),    32'd0);
    check("t6_bits",   32'(sym_bits),    32'd0);
    check("t6_mode",   32'(sym_mode),    32'd0);
    check("t6_busy",   32'(busy),        32'd0);
    #10;
    rst_n = 1'b1;
    sym_ready = 1'b1; mod_type = 2'd1;
    @(posedge clk); #1;
    send(1'b0);
    check("t6_nv",     32'(sym_valid), 32'd0);
    send(1'b1);
    check("t6_v",      32'(sym_valid), 32'd1);
    check("t6_d",      32'(sym_data),  32'h02);
    check("t6_b",      32'(sym_bits),  32'd2);
    check("t6_m",      32'(sym_mode),  32'd1);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
